// File: rtl/io_mmio_ctrl.sv
// MIPS150 memory-mapped I/O controller: UART TX holding register, RX buffer, cycle/instruction counters.
// Define IO_RX_FIFO_EN for a 2^RX_FIFO_AW-entry RX FIFO; otherwise the RX buffer holds a single byte.
module io_mmio_ctrl #(
  parameter int unsigned RX_FIFO_AW = 3,
  parameter logic [3:0]  IO_BASE    = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic        inst_valid,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

`ifdef IO_RX_FIFO_EN
  localparam int unsigned OCC_W = RX_FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << RX_FIFO_AW;
`else
  localparam int unsigned OCC_W     = 1;
  localparam int unsigned UNUSED_AW = RX_FIFO_AW;
`endif

  logic             hit_s;
  logic             ld_s;
  logic             st_s;
  logic [7:0]       off_s;
  logic             push_s;
  logic             pop_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic [7:0]       rx_head_s;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             tx_empty_q, tx_empty_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [31:0]      cyc_cnt_q, cyc_cnt_d;
  logic [31:0]      ins_cnt_q, ins_cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      status_s;
  logic [31:0]      rd_word_s;
  logic             unused_s;

  // Only addr[7:2] decodes a register; the byte lane and the upper region bits are don't-care.
  assign hit_s    = (addr[31:28] == IO_BASE) && !stall;
  assign off_s    = {addr[7:2], 2'b00};
  assign ld_s     = hit_s && ld_en;
  assign st_s     = hit_s && st_en;
  assign unused_s = ^{addr[27:8], addr[1:0], wdata[31:8]};

  assign rx_empty_s    = (occ_q == '0);
  assign uart_rx_ready = !rx_full_s && !rst;
  assign push_s        = uart_rx_valid && uart_rx_ready;
  assign pop_s         = ld_s && (off_s == OFF_RXDATA) && !rx_empty_s;

`ifdef IO_RX_FIFO_EN
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [RX_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RX_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;

  assign rx_full_s = (occ_q == OCC_W'(DEPTH));
  assign rx_head_s = mem_q[rd_ptr_q];

  // RX FIFO next state: pointers wrap naturally at the power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = uart_rx_data;
      wr_ptr_d        = wr_ptr_q + RX_FIFO_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + RX_FIFO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // RX FIFO state register
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: 8'h00};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
`else
  logic [7:0] rx_byte_q, rx_byte_d;

  assign rx_full_s = occ_q[0];
  assign rx_head_s = rx_byte_q;

  // Single-byte RX buffer: push and pop never coincide because ready requires empty.
  always_comb begin
    rx_byte_d = rx_byte_q;
    occ_d     = occ_q;
    if (push_s) begin
      rx_byte_d = uart_rx_data;
      occ_d     = 1'b1;
    end else if (pop_s) begin
      occ_d = 1'b0;
    end else begin
      occ_d = occ_q;
    end
  end

  // RX byte register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q <= 8'h00;
      occ_q     <= '0;
    end else begin
      rx_byte_q <= rx_byte_d;
      occ_q     <= occ_d;
    end
  end
`endif

  // Status word built from pre-access state.
  always_comb begin
    status_s             = 32'd0;
    status_s[0]          = tx_empty_q;
    status_s[1]          = !rx_empty_s;
    status_s[8 +: OCC_W] = occ_q;
  end

  // Load mux and registered read data; rdata holds when there is no load.
  always_comb begin
    case (off_s)
      OFF_STATUS: rd_word_s = status_s;
      OFF_RXDATA: rd_word_s = pop_s ? {24'd0, rx_head_s} : 32'd0;
      OFF_CYCLE:  rd_word_s = cyc_cnt_q;
      OFF_INSTR:  rd_word_s = ins_cnt_q;
      default:    rd_word_s = 32'd0;
    endcase
    if (ld_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // TX holding register; a store only lands while empty, so it never races the release.
  always_comb begin
    tx_empty_d = tx_empty_q;
    tx_data_d  = tx_data_q;
    if (st_s && (off_s == OFF_TXDATA) && tx_empty_q) begin
      tx_empty_d = 1'b0;
      tx_data_d  = wdata[7:0];
    end else if (!tx_empty_q && uart_tx_ready) begin
      tx_empty_d = 1'b1;
    end else begin
      tx_empty_d = tx_empty_q;
    end
  end

  // Counters; a clear store wins over the same-cycle increment.
  always_comb begin
    if (st_s && (off_s == OFF_CLEAR)) begin
      cyc_cnt_d = 32'd0;
      ins_cnt_d = 32'd0;
    end else begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
      ins_cnt_d = (inst_valid && !stall) ? (ins_cnt_q + 32'd1) : ins_cnt_q;
    end
  end

  // TX, counter and read-data state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_empty_q <= 1'b1;
      tx_data_q  <= 8'h00;
      cyc_cnt_q  <= 32'd0;
      ins_cnt_q  <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      tx_empty_q <= tx_empty_d;
      tx_data_q  <= tx_data_d;
      cyc_cnt_q  <= cyc_cnt_d;
      ins_cnt_q  <= ins_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata         = rdata_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = !tx_empty_q;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: directed table, corner sequences and a randomized run
// against a queue-based reference model. Honours IO_RX_FIFO_EN for the RX depth.
module tb_io_mmio_ctrl;

  logic        clk;
  logic        rst, stall, ld_en, st_en, inst_valid;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;

`ifdef IO_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  io_mmio_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .addr(addr), .wdata(wdata),
    .ld_en(ld_en), .st_en(st_en), .inst_valid(inst_valid), .rdata(rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  rxq[$];
  logic        m_tx_empty;
  logic [7:0]  m_tx_data;
  logic [31:0] m_cyc, m_ins, m_rdata;

  typedef struct {
    logic [31:0] a;
    logic        stl;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%08h required=%08h", nm, $time, act, exp);
    end
  endtask

  // One clock edge of the specified behaviour, applied to the inputs currently driven.
  task automatic model();
    logic       hit, tx_done, tx_take, clr;
    logic [7:0] off;
    int         occ;
    if (rst) begin
      rxq.delete();
      m_tx_empty = 1'b1;
      m_tx_data  = 8'h00;
      m_cyc      = 32'd0;
      m_ins      = 32'd0;
      m_rdata    = 32'd0;
    end else begin
      hit = (addr[31:28] == 4'h8) && !stall;
      off = {addr[7:2], 2'b00};
      occ = rxq.size();
      if (hit && ld_en) begin
        case (off)
          8'h00:   m_rdata = (32'(occ) << 8) | ((occ > 0) ? 32'd2 : 32'd0) | (m_tx_empty ? 32'd1 : 32'd0);
          8'h04:   m_rdata = (occ > 0) ? {24'd0, rxq[0]} : 32'd0;
          8'h10:   m_rdata = m_cyc;
          8'h14:   m_rdata = m_ins;
          default: m_rdata = 32'd0;
        endcase
      end
      if (hit && ld_en && off == 8'h04 && occ > 0) void'(rxq.pop_front());
      if (uart_rx_valid && occ < DEPTH) rxq.push_back(uart_rx_data);
      tx_done = !m_tx_empty && uart_tx_ready;
      tx_take = hit && st_en && off == 8'h08 && m_tx_empty;
      if (tx_take) begin
        m_tx_empty = 1'b0;
        m_tx_data  = wdata[7:0];
      end
      if (tx_done) m_tx_empty = 1'b1;
      clr   = hit && st_en && off == 8'h18;
      m_cyc = clr ? 32'd0 : m_cyc + 32'd1;
      m_ins = clr ? 32'd0 : ((inst_valid && !stall) ? m_ins + 32'd1 : m_ins);
    end
  endtask

  task automatic tick();
    #1;
    chk("rx_ready", 32'(uart_rx_ready), 32'(!rst && rxq.size() < DEPTH));
    @(posedge clk);
    model();
    #1;
    chk("rdata", rdata, m_rdata);
    chk("tx_valid", 32'(uart_tx_valid), 32'(!m_tx_empty));
    chk("tx_data", 32'(uart_tx_data), 32'(m_tx_data));
  endtask

  task automatic do_op(input logic l, input logic s, input logic [31:0] a, input logic [31:0] d);
    ld_en = l; st_en = s; addr = a; wdata = d;
    tick();
    ld_en = 1'b0; st_en = 1'b0;
  endtask

  task automatic idle();
    do_op(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    idle();
    uart_rx_valid = 1'b0;
  endtask

  task automatic tx_ack();
    uart_tx_ready = 1'b1;
    idle();
    uart_tx_ready = 1'b0;
  endtask

  logic [5:0] offs[9];

  initial begin
    tbl[0]  = '{32'h8000_0000, 1'b0, 32'h0000_0001, "tbl_status"};
    tbl[1]  = '{32'h8000_0004, 1'b0, 32'h0000_0000, "tbl_rx_empty"};
    tbl[2]  = '{32'h8000_0008, 1'b0, 32'h0000_0000, "tbl_txreg_read"};
    tbl[3]  = '{32'h8000_000C, 1'b0, 32'h0000_0000, "tbl_unmapped_0c"};
    tbl[4]  = '{32'h8ABC_D003, 1'b0, 32'h0000_0001, "tbl_status_alias"};
    tbl[5]  = '{32'h8000_0018, 1'b0, 32'h0000_0000, "tbl_clear_read"};
    tbl[6]  = '{32'h8000_0040, 1'b0, 32'h0000_0000, "tbl_unmapped_40"};
    tbl[7]  = '{32'h8000_0000, 1'b0, 32'h0000_0001, "tbl_status2"};
    tbl[8]  = '{32'h9000_0004, 1'b0, 32'h0000_0001, "tbl_off_region_hold"};
    tbl[9]  = '{32'h8000_0018, 1'b1, 32'h0000_0001, "tbl_stall_hold"};
    tbl[10] = '{32'h8000_00FC, 1'b0, 32'h0000_0000, "tbl_unmapped_fc"};
    tbl[11] = '{32'h8000_0100, 1'b0, 32'h0000_0001, "tbl_status_wrap8"};
    offs = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd16};

    rst = 1'b1; stall = 1'b0; ld_en = 1'b0; st_en = 1'b0; inst_valid = 1'b0;
    addr = 32'd0; wdata = 32'd0; uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("rst_tx_data", 32'(uart_tx_data), 32'd0);
    chk("rst_rx_ready", 32'(uart_rx_ready), 32'd0);
    rst = 1'b0;

    // Idle 10 cycles, then read the cycle counter and status
    repeat (10) idle();
    do_op(1'b1, 1'b0, 32'h8000_0010, 32'd0);
    chk("cyc_after_idle", rdata, 32'd10);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0);
    chk("status_idle", rdata, 32'h0000_0001);
    chk("rx_ready_idle", 32'(uart_rx_ready), 32'd1);

    // Directed register-map table
    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stl;
      do_op(1'b1, 1'b0, tbl[i].a, 32'd0);
      stall = 1'b0;
      chk(tbl[i].nm, rdata, tbl[i].exp);
    end

    // TX: held byte survives a second store while not empty
    do_op(1'b0, 1'b1, 32'h8000_0008, 32'h0000_0041);
    repeat (5) idle();
    do_op(1'b0, 1'b1, 32'h8000_0008, 32'h0000_0042);
    chk("tx_hold_data", 32'(uart_tx_data), 32'h41);
    chk("tx_hold_valid", 32'(uart_tx_valid), 32'd1);
    tx_ack();
    chk("tx_released", 32'(uart_tx_valid), 32'd0);
    do_op(1'b0, 1'b1, 32'h8000_0008, 32'hFFFF_FF43);
    chk("tx_store_after_ack", 32'(uart_tx_data), 32'h43);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0);
    chk("status_tx_busy", rdata, 32'd0);
    tx_ack();
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0);
    chk("status_tx_empty", rdata, 32'd1);

    // RX ordering and empty pop
`ifdef IO_RX_FIFO_EN
    push(8'h10); push(8'h20); push(8'h30);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop0", rdata, 32'h10);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop1", rdata, 32'h20);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop2", rdata, 32'h30);
`else
    push(8'h10);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop0", rdata, 32'h10);
    push(8'h20);
    push(8'h99);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop1_full_drop", rdata, 32'h20);
    push(8'h30);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop2", rdata, 32'h30);
`endif
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop_empty", rdata, 32'd0);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0);
    uart_rx_valid = 1'b0;
    chk("rx_push_pop_empty", rdata, 32'd0);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("rx_pop_late", rdata, 32'h5A);

`ifdef IO_RX_FIFO_EN
    // Fill, simultaneous push/pop across the pointer wrap, then drain
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    chk("rx_full_ready", 32'(uart_rx_ready), 32'd0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0); chk("status_full", rdata, 32'h0000_0803);
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("fifo_pop_a0", rdata, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'(8'hB0 + i);
      do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0);
      chk("fifo_pushpop", rdata, 32'(8'hA1 + i));
    end
    uart_rx_valid = 1'b0;
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0); chk("status_occ7", rdata, 32'h0000_0703);
    push(8'hB4);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0); chk("status_refull", rdata, 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0);
      chk("fifo_drain", rdata, (i < 3) ? 32'(8'hA5 + i) : 32'(8'hB0 + i - 3));
    end
`endif

    // Cycle counter wrap
    force dut.cyc_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_cnt_q;
    m_cyc = 32'hFFFF_FFFE;
    repeat (3) idle();
    do_op(1'b1, 1'b0, 32'h8000_0010, 32'd0);
    chk("cyc_wrap", rdata, 32'd1);

    // Instruction counter, stalled retirement, and clear overriding increment
    inst_valid = 1'b1;
    repeat (3) idle();
    stall = 1'b1; idle(); stall = 1'b0;
    inst_valid = 1'b0;
    do_op(1'b1, 1'b0, 32'h8000_0014, 32'd0);
    chk("ins_count", rdata, 32'd3);
    inst_valid = 1'b1;
    do_op(1'b0, 1'b1, 32'h8000_0018, 32'd0);
    inst_valid = 1'b0;
    do_op(1'b1, 1'b0, 32'h8000_0010, 32'd0); chk("cyc_cleared", rdata, 32'd0);
    do_op(1'b1, 1'b0, 32'h8000_0014, 32'd0); chk("ins_cleared", rdata, 32'd0);

    // Stall suppresses pop, TX latch and rdata update
    push(8'h66);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd0); chk("status_one", rdata, 32'h0000_0103);
    stall = 1'b1;
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0); chk("stall_rdata_hold", rdata, 32'h0000_0103);
    do_op(1'b0, 1'b1, 32'h8000_0008, 32'h55);   chk("stall_no_tx", 32'(uart_tx_valid), 32'd0);
    stall = 1'b0;
    do_op(1'b1, 1'b0, 32'h8000_0004, 32'd0);  chk("unstall_pop", rdata, 32'h66);
    do_op(1'b0, 1'b1, 32'h8000_0008, 32'h55);   chk("unstall_tx", 32'(uart_tx_data), 32'h55);
    tx_ack();

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      int op;
      op            = int'($urandom_range(0, 99));
      rst           = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      inst_valid    = 1'($urandom_range(0, 1));
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_rx_data  = 8'($urandom);
      addr  = {(($urandom_range(0, 7) == 0) ? 4'h7 : 4'h8), 20'($urandom),
               offs[$urandom_range(0, 8)], 2'($urandom)};
      wdata = $urandom;
      ld_en = (op < 35);
      st_en = (op >= 35) && (op < 60);
      tick();
    end
    rst = 1'b0; stall = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    inst_valid = 1'b0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
